// File: rtl/teclado_if.sv
// Keypad producer/consumer bundle: raw buttons and acknowledge in, load pulses and status out.
interface teclado_if;
  logic [3:0] tecla_n;
  logic       rtecla;
  logic       load1;
  logic       load2;
  logic       load3;
  logic       load4;
  logic       pendiente;
  logic [2:0] estado_dbg;

  modport master (
    input  tecla_n, rtecla,
    output load1, load2, load3, load4, pendiente, estado_dbg
  );

  modport slave (
    output tecla_n, rtecla,
    input  load1, load2, load3, load4, pendiente, estado_dbg
  );
endinterface

// File: rtl/teclado_scanner.sv
// Four-button keypad conditioner: 2-FF sync, press/release debounce, single-key check,
// one registered load pulse per accepted press, lockout until the consumer acknowledges.
module teclado_scanner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic      clk,
  input logic      rst_n,
  teclado_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DB_PRESS = 3'd1;
  localparam logic [2:0] EMIT     = 3'd2;
  localparam logic [2:0] WAIT_REL = 3'd3;
  localparam logic [2:0] DB_REL   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       s;
  logic [2:0]       estado;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       patron;
  logic [3:0]       load;
  logic             pendiente;
  logic             bloqueo;
  logic             liberado;
  logic             una_tecla;

  assign liberado  = (s == 4'b1111);
  assign una_tecla = s inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Saturating increment: the counter never wraps, whatever DEBOUNCE_CYCLES is.
  assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;

  // NOTE: every register here uses non-blocking assignment, so all reads in this block
  // see pre-edge values; later assignments in the same block override earlier ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 4'b1111;
      s         <= 4'b1111;
      estado    <= IDLE;
      cnt       <= '0;
      patron    <= 4'b1111;
      load      <= 4'b0000;
      pendiente <= 1'b0;
      bloqueo   <= 1'b0;
    end else begin
      sync1 <= bus.tecla_n;
      s     <= sync1;
      load  <= 4'b0000;

      // The acknowledge is ignored during EMIT so the key just delivered stays pending.
      if (bus.rtecla && estado != EMIT) pendiente <= 1'b0;

      case (estado)
        IDLE: begin
          // A key seen while pending must be fully released before it can fire again.
          if (liberado)       bloqueo <= 1'b0;
          else if (pendiente) bloqueo <= 1'b1;
          if (una_tecla && !pendiente && !bloqueo) begin
            estado <= DB_PRESS;
            patron <= s;
            cnt    <= '0;
          end
        end
        DB_PRESS: begin
          if (s != patron) begin
            estado <= IDLE;
            cnt    <= '0;
          end else if (cnt >= CNT_LAST) begin
            estado    <= EMIT;
            cnt       <= '0;
            load      <= ~patron;
            pendiente <= 1'b1;
          end else begin
            cnt <= cnt_next;
          end
        end
        EMIT: begin
          estado <= WAIT_REL;
          cnt    <= '0;
        end
        WAIT_REL: begin
          if (liberado) begin
            estado <= DB_REL;
            cnt    <= '0;
          end
        end
        DB_REL: begin
          if (!liberado) begin
            estado <= WAIT_REL;
            cnt    <= '0;
          end else if (cnt >= CNT_LAST) begin
            estado <= IDLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: begin
          estado <= IDLE;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.load1      = load[0];
  assign bus.load2      = load[1];
  assign bus.load3      = load[2];
  assign bus.load4      = load[3];
  assign bus.pendiente  = pendiente;
  assign bus.estado_dbg = estado;

endmodule

// File: tb/tb_teclado_scanner.sv
// Bench for teclado_scanner: directed scenarios with literal expectations plus random
// stimulus, all compared every cycle against a run-length reference model.
module tb_teclado_scanner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  teclado_if bus ();

  teclado_scanner #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [3:0] dut_load;
  assign dut_load = {bus.load4, bus.load3, bus.load2, bus.load1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronised vector is the raw input two samples late; a press
  // fires after D+1 consecutive identical single-key samples taken while ready; a release
  // completes after D+1 consecutive all-high samples following the pulse cycle.
  logic [3:0] m_q1, m_q2, m_cand, m_load;
  int         m_run, m_rel_run;
  bit         m_emit, m_rel, m_pend, m_lock;

  task automatic model_reset();
    m_q1 = 4'hF; m_q2 = 4'hF; m_cand = 4'h0; m_load = 4'h0;
    m_run = 0; m_rel_run = 0; m_emit = 0; m_rel = 0; m_pend = 0; m_lock = 0;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] raw, input logic rt);
    logic [3:0] sv;
    bit was_emit, fire;
    sv = m_q2;
    if (!rst) begin
      model_reset();
      return;
    end
    m_q2 = m_q1;
    m_q1 = raw;
    was_emit = m_emit;
    fire = 0;
    m_load = 4'h0;
    if (was_emit) begin
      m_emit = 0; m_rel = 1; m_rel_run = 0;
    end else if (m_rel) begin
      m_rel_run = (sv == 4'hF) ? m_rel_run + 1 : 0;
      if (m_rel_run == D + 1) m_rel = 0;
    end else if (m_cand != 4'h0) begin
      if (sv == m_cand) begin
        m_run++;
        if (m_run == D + 1) begin
          fire = 1;
          m_load = ~m_cand;
          m_cand = 4'h0;
        end
      end else begin
        m_cand = 4'h0;
      end
    end else begin
      if ($countones(~sv) == 1 && !m_pend && !m_lock) begin
        m_cand = sv;
        m_run = 1;
      end
      if (sv == 4'hF) m_lock = 0;
      else if (m_pend) m_lock = 1;
    end
    if (fire) begin
      m_emit = 1;
      m_pend = 1;
    end else if (!was_emit && rt) begin
      m_pend = 0;
    end
  endtask

  function automatic logic [2:0] model_state();
    if (m_cand != 4'h0) return 3'd1;
    if (m_emit)         return 3'd2;
    if (m_rel)          return (m_rel_run == 0) ? 3'd3 : 3'd4;
    return 3'd0;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step(rst_n, bus.tecla_n, bus.rtecla);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_load", {28'd0, dut_load}, {28'd0, m_load});
        check("model_pend", {31'd0, bus.pendiente}, {31'd0, m_pend});
        check("model_state", {29'd0, bus.estado_dbg}, {29'd0, model_state()});
      end
    end
  end

  task automatic drive(input logic [3:0] k, input logic rt, input int n);
    bus.tecla_n = k;
    bus.rtecla  = rt;
    repeat (n) @(negedge clk);
  endtask

  // Counts edges until a load appears (bounded), then checks latency and which key fired.
  task automatic measure(input string name, input logic [3:0] exp_load, input int exp_edges);
    int k;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dut_load != 4'h0) break;
    end
    check({name, "_latency"}, k, exp_edges);
    check({name, "_load"}, {28'd0, dut_load}, {28'd0, exp_load});
  endtask

  task automatic count_loads(input logic [3:0] k, input logic rt, input int n, output int seen);
    seen = 0;
    bus.tecla_n = k;
    bus.rtecla  = rt;
    repeat (n) begin
      @(negedge clk);
      if (dut_load != 4'h0) seen++;
    end
  endtask

  task automatic idle_clear();
    drive(4'hF, 1'b0, 12);
    drive(4'hF, 1'b1, 1);
    drive(4'hF, 1'b0, 3);
  endtask

  initial begin
    int seen;
    logic [3:0] pat;
    int hold;
    rst_n = 1'b0;
    bus.tecla_n = 4'b1110;
    bus.rtecla = 1'b0;

    // Reset with key1 held, then release reset.
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_load", {28'd0, dut_load}, 32'd0);
    check("rst_pend", {31'd0, bus.pendiente}, 32'd0);
    check("rst_state", {29'd0, bus.estado_dbg}, 32'd0);
    rst_n = 1'b1;
    measure("rst_key1", 4'b0001, D + 3);
    @(negedge clk);
    check("key1_width", {28'd0, dut_load}, 32'd0);
    check("key1_pend", {31'd0, bus.pendiente}, 32'd1);
    check("key1_wait_rel", {29'd0, bus.estado_dbg}, 32'd3);
    idle_clear();
    check("ack_pend", {31'd0, bus.pendiente}, 32'd0);

    // Clean key3 press, acknowledge, then key2.
    bus.tecla_n = 4'b1011;
    measure("key3", 4'b0100, D + 3);
    @(negedge clk);
    check("key3_pend", {31'd0, bus.pendiente}, 32'd1);
    drive(4'b1011, 1'b0, 12);
    drive(4'hF, 1'b0, 12);
    drive(4'hF, 1'b1, 1);
    bus.rtecla = 1'b0;
    check("key3_ack", {31'd0, bus.pendiente}, 32'd0);
    bus.tecla_n = 4'b1101;
    measure("key2", 4'b0010, D + 3);
    idle_clear();

    // Bouncing key2: three 2-cycle low bursts must not fire.
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      int a, b;
      count_loads(4'b1101, 1'b0, 2, a);
      count_loads(4'hF, 1'b0, 2, b);
      seen += a + b;
    end
    check("bounce_quiet", seen, 0);
    bus.tecla_n = 4'b1101;
    measure("bounce_key2", 4'b0010, D + 3);
    idle_clear();

    // Two keys together are ignored; dropping one leaves a valid key1 press.
    count_loads(4'b1100, 1'b0, 20, seen);
    check("two_keys_quiet", seen, 0);
    check("two_keys_idle", {29'd0, bus.estado_dbg}, 32'd0);
    bus.tecla_n = 4'b1110;
    measure("two_keys_key1", 4'b0001, D + 3);

    // Lockout: key1 unacknowledged, key4 must not fire, even across rtecla while held.
    drive(4'hF, 1'b0, 12);
    count_loads(4'b0111, 1'b0, 20, seen);
    check("lockout_quiet", seen, 0);
    drive(4'b0111, 1'b1, 1);
    count_loads(4'b0111, 1'b0, 20, seen);
    check("lockout_held", seen, 0);
    check("lockout_pend", {31'd0, bus.pendiente}, 32'd0);
    drive(4'hF, 1'b0, 4);
    bus.tecla_n = 4'b0111;
    measure("repress_key4", 4'b1000, D + 3);
    idle_clear();

    // rtecla during the pulse cycle leaves the new key pending.
    bus.tecla_n = 4'b1101;
    measure("emit_key2", 4'b0010, D + 3);
    bus.rtecla = 1'b1;
    @(negedge clk);
    bus.rtecla = 1'b0;
    check("emit_rtecla_pend", {31'd0, bus.pendiente}, 32'd1);
    idle_clear();

    // Reset in the second debounce cycle aborts the press.
    drive(4'b1110, 1'b0, 4);
    check("abort_in_db", {29'd0, bus.estado_dbg}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_state", {29'd0, bus.estado_dbg}, 32'd0);
    check("abort_pend", {31'd0, bus.pendiente}, 32'd0);
    check("abort_load", {28'd0, dut_load}, 32'd0);
    rst_n = 1'b1;
    count_loads(4'hF, 1'b0, 10, seen);
    check("abort_quiet", seen, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c += hold) begin
      case ($urandom_range(0, 7))
        0, 1:    pat = 4'hF;
        2:       pat = 4'b1110;
        3:       pat = 4'b1101;
        4:       pat = 4'b1011;
        5:       pat = 4'b0111;
        default: pat = 4'($urandom);
      endcase
      hold = $urandom_range(1, 12);
      bus.tecla_n = pat;
      for (int j = 0; j < hold; j++) begin
        bus.rtecla = ($urandom_range(0, 7) == 0);
        rst_n = ($urandom_range(0, 399) != 0);
        @(negedge clk);
      end
      rst_n = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/teclado_scanner.md
Name: teclado_scanner

Overview:
- Producer side of the bike-rack keypad interface. Conditions four raw push-buttons: 2-FF sync, debounce, single-key validation.
- Emits one single-cycle load pulse (load1..load4) per accepted press, feeding the keypad datapath that latches teclaoprimida.
- Holds off further presses until the consumer returns rtecla, so no key is overwritten before it is consumed.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required for press and release (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, debounce counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- tecla_n  input  4  raw buttons, active-low, asynchronous; bit0=key1 .. bit3=key4.
- rtecla  input  1  consumer acknowledge/clear, 1-cycle pulse or level.
- load1  output  1  1-cycle pulse, key 1 accepted.
- load2  output  1  1-cycle pulse, key 2 accepted.
- load3  output  1  1-cycle pulse, key 3 accepted.
- load4  output  1  1-cycle pulse, key 4 accepted.
- pendiente  output  1  high from accepted press until rtecla.
- estado_dbg  output  3  current FSM state code.

Behaviour:
- Reset (rst_n=0 at rising edge): sync flops = 4'b1111, state IDLE, counter 0, load1..4=0, pendiente=0, estado_dbg=0. Reset mid-debounce or mid-pulse aborts with no load emitted.
- Sync: 2 flops per bit; FSM sees only the synced vector s. Valid press = exactly one bit of s low. All-high = released. Two or more low = invalid.
- State codes: IDLE=0, DB_PRESS=1, EMIT=2, WAIT_REL=3, DB_REL=4.
- IDLE:
  - Valid press and pendiente=0 -> DB_PRESS; capture pattern, counter=0.
  - Invalid, released, or pendiente=1 -> stay.
- DB_PRESS:
  - Each cycle s equals captured pattern -> counter+1. Counter reaches DEBOUNCE_CYCLES-1 -> EMIT.
  - Any mismatch, including a second key -> IDLE, counter=0, no load.
- EMIT (exactly 1 cycle): the load bit for the captured key is registered high; the others stay 0. Set pendiente=1. Always go to WAIT_REL.
- WAIT_REL: s all-high -> DB_REL, counter=0. Otherwise stay, even with extra keys pressed.
- DB_REL: s all-high for DEBOUNCE_CYCLES consecutive cycles -> IDLE. Any low bit -> WAIT_REL, counter=0.
- Latency: raw falling edge held stable -> load high on rising edge number DEBOUNCE_CYCLES+3 after the first edge sampling it. That is 2 sync + 1 IDLE + DEBOUNCE_CYCLES debounce. Timing is fixed and exact.
- Timing: load outputs are registered and launched on the rising edge. This gives the datapath's falling-edge capture a half-cycle of setup.
- pendiente:
  - Cleared on any cycle with rtecla=1, except the EMIT cycle.
  - rtecla in the same cycle as EMIT: pendiente ends 1, because the new key is unconsumed.
  - rtecla while pendiente=0 is ignored.
- A key held through rtecla does not re-fire; a full release is required.
- Counter saturates: it never wraps. It is reset on every state entry.
- No combinational path from inputs to outputs.

Test Plan:
(all with DEBOUNCE_CYCLES=4)
- Reset: rst_n=0 for 3 cycles with tecla_n=4'b1110 -> all loads 0, pendiente=0, estado_dbg=0. Release reset, keep key held -> load1 pulses exactly 7 cycles later, one cycle wide.
- Clean press of key3: tecla_n=4'b1011 held 20 cycles, then 4'b1111 -> single load3 pulse at cycle 7, pendiente=1. Apply rtecla pulse -> pendiente=0. Press key2 -> load2 fires.
- Bounce: key2 toggles low/high every 2 cycles for 12 cycles, then stays low -> no load during bounce. load2 fires 7 cycles after the final stable falling edge.
- Two keys: tecla_n=4'b1100 held 20 cycles -> no load, FSM stays in IDLE. Release bit1 (4'b1110) -> load1 after debounce.
- Lockout: accept key1, hold no rtecla, release, press key4 for 20 cycles -> no load4. Assert rtecla while key4 is still held -> still no load4 until release and re-press.
- Simultaneous events: assert rtecla on the EMIT cycle of key2 -> pendiente=1 afterwards. Assert rst_n=0 in DB_PRESS cycle 2 -> no load, state IDLE, pendiente=0.
